// File: rtl/sp_ram_pkg.sv
// Shared state/port types and the read latency of the arbitrated single-port RAM.
// SP_RAM_ARB2_OREG_EN adds the RAM output register and raises RD_LAT from 1 to 2.
package sp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

`ifdef SP_RAM_ARB2_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/sp_ram_core.sv
// Inferred single-port RAM, write-through read register; 1 cycle, or 2 with SP_RAM_ARB2_OREG_EN.
// No backpressure: every enabled cycle performs exactly one read or write.
module sp_ram_core #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_ce,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (i_ce) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
                r_rd          <= i_din;
            end else begin
                r_rd <= r_mem[i_addr];
            end
        end
    end

`ifdef SP_RAM_ARB2_OREG_EN
    // Free-running output stage: the word read in cycle N lands here at N+2.
    logic [DATA_W-1:0] r_oreg;

    always_ff @(posedge clk) begin
        r_oreg <= r_rd;
    end

    assign o_dout = r_oreg;
`else
    assign o_dout = r_rd;
`endif

endmodule

// File: rtl/sp_ram_arb2.sv
// Single-port RAM shared by two req/gnt masters (round-robin on conflict) with post-reset clear sweep.
// Read data RD_LAT cycles after grant (SP_RAM_ARB2_OREG_EN selects 2); requesters hold until gnt.
module sp_ram_arb2
    import sp_ram_pkg::*;
#(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              clear_busy
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_clear_busy;
    port_id_t          r_rr_last;
    logic [RD_LAT-1:0] r_vld;
    port_id_t          r_tag [RD_LAT];
    logic [DATA_W-1:0] r_a_hold;
    logic [DATA_W-1:0] r_b_hold;

    logic              w_run;
    logic              w_conflict;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_ce;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_dout;
    logic              w_out_vld;
    port_id_t          w_out_tag;

    assign w_run      = (r_state == ST_RUN);
    assign w_conflict = a_req & b_req;
    // On a conflict the port that did not win the previous conflict goes first.
    assign w_a_gnt    = w_run & a_req & (~b_req | (r_rr_last == PORT_B));
    assign w_b_gnt    = w_run & b_req & (~a_req | (r_rr_last == PORT_A));

    always_comb begin
        w_ce   = 1'b1;
        w_we   = 1'b1;
        w_addr = r_clr_cnt[ADDR_W-1:0];
        w_din  = CLEAR_VAL;
        if (w_run) begin
            w_ce = w_a_gnt | w_b_gnt;
            if (w_b_gnt) begin
                w_we   = b_we;
                w_addr = b_addr;
                w_din  = b_wdata;
            end else begin
                w_we   = a_we;
                w_addr = a_addr;
                w_din  = a_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_clear_busy <= 1'b1;
            r_rr_last    <= PORT_B;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + CNT_ONE;
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state      <= ST_RUN;
                        r_clear_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_conflict) begin
                        r_rr_last <= w_a_gnt ? PORT_A : PORT_B;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    // Read-valid / requester-tag pipeline matching the RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= PORT_A;
            end
        end else begin
            r_vld[0] <= (w_a_gnt | w_b_gnt) & ~w_we;
            r_tag[0] <= w_b_gnt ? PORT_B : PORT_A;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_out_vld = r_vld[RD_LAT-1];
    assign w_out_tag = r_tag[RD_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_hold <= '0;
            r_b_hold <= '0;
        end else begin
            if (a_rvalid) r_a_hold <= w_dout;
            if (b_rvalid) r_b_hold <= w_dout;
        end
    end

    sp_ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk    (clk),
        .i_ce   (w_ce),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_din  (w_din),
        .o_dout (w_dout)
    );

    assign a_gnt      = w_a_gnt;
    assign b_gnt      = w_b_gnt;
    assign a_rvalid   = w_out_vld & (w_out_tag == PORT_A);
    assign b_rvalid   = w_out_vld & (w_out_tag == PORT_B);
    assign a_rdata    = a_rvalid ? w_dout : r_a_hold;
    assign b_rdata    = b_rvalid ? w_dout : r_b_hold;
    assign clear_busy = r_clear_busy;

endmodule

// File: tb/tb_sp_ram_arb2.sv
// Bench for sp_ram_arb2: per-cycle comparison against a queue/array reference plus directed literals.
`timescale 1ns/1ps
module tb_sp_ram_arb2;
    import sp_ram_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLR = 8'h00;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy;
    logic [DW-1:0] a_rdata, b_rdata;

    always #5 clk = ~clk;

    sp_ram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(CLR)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clear_busy(clear_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole memory array, FIFO of pending reads with due tick, last conflict winner.
    typedef struct {
        int            due;
        bit            pb;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    rd_t           m_q[$];
    int            tick = 0;
    int            m_rel = 0;
    bit            m_last_b = 1'b1;
    bit            m_in_reset = 1'b0;
    logic [DW-1:0] m_ah = '0, m_bh = '0;

    always @(negedge clk) begin
        bit  ea, eb, eav, ebv, run;
        rd_t r;
        tick++;
        ea = 0; eb = 0; eav = 0; ebv = 0; run = 0;
        if (!reset_n) begin
            if (!m_in_reset) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] = CLR;
            end
            m_in_reset = 1'b1;
            m_q.delete();
            m_rel = 0;
            m_last_b = 1'b1;
            m_ah = '0;
            m_bh = '0;
        end else begin
            m_in_reset = 1'b0;
            run = (m_rel >= DEPTH);
            while (m_q.size() > 0 && m_q[0].due <= tick) begin
                r = m_q.pop_front();
                if (r.due == tick) begin
                    if (r.pb) begin ebv = 1; m_bh = r.d; end
                    else      begin eav = 1; m_ah = r.d; end
                end
            end
            if (run) begin
                if (a_req && b_req) begin
                    if (m_last_b) ea = 1; else eb = 1;
                end else begin
                    ea = a_req;
                    eb = b_req;
                end
            end
        end
        chk("a_gnt",      32'(a_gnt),      32'(ea));
        chk("b_gnt",      32'(b_gnt),      32'(eb));
        chk("a_rvalid",   32'(a_rvalid),   32'(eav));
        chk("b_rvalid",   32'(b_rvalid),   32'(ebv));
        chk("a_rdata",    32'(a_rdata),    32'(m_ah));
        chk("b_rdata",    32'(b_rdata),    32'(m_bh));
        chk("clear_busy", 32'(clear_busy), 32'(!reset_n || (m_rel < DEPTH)));
        if (reset_n) begin
            if (ea) begin
                if (a_we) m_mem[a_addr] = a_wdata;
                else      m_q.push_back('{tick + RD_LAT, 1'b0, m_mem[a_addr]});
            end
            if (eb) begin
                if (b_we) m_mem[b_addr] = b_wdata;
                else      m_q.push_back('{tick + RD_LAT, 1'b1, m_mem[b_addr]});
            end
            if (run && a_req && b_req) m_last_b = eb;
            if (m_rel <= DEPTH) m_rel++;
        end
    end

    task automatic wait_sweep(inout int cnt);
        int guard = 0;
        forever begin
            @(negedge clk);
            if (!clear_busy || guard > DEPTH + 16) break;
            cnt++;
            guard++;
        end
    endtask

    task automatic op(input bit pb, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        int g = 0;
        @(posedge clk); #1;
        if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = d; end
        else    begin a_req = 1; a_we = we; a_addr = ad; a_wdata = d; end
        forever begin
            @(negedge clk);
            if ((pb ? b_gnt : a_gnt) || g >= 64) break;
            g++;
        end
        chk(pb ? "b_op_gnt" : "a_op_gnt", 32'(pb ? b_gnt : a_gnt), 32'(1));
        @(posedge clk); #1;
        if (pb) b_req = 0; else a_req = 0;
    endtask

    task automatic rd_wait();
        repeat (RD_LAT - 1) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int k;
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        k = $urandom_range(0, 15);
        return (k < 8) ? AW'(k) : AW'(DEPTH - 16 + k);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  busy_n;
        bit  ap, bp, ga, gb;
        int  g;
        ap = 0; bp = 0; ga = 0; gb = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(clear_busy), 32'(1));
        chk("rst_rdata", 32'(a_rdata), 32'(0));
        @(posedge clk); #1 reset_n = 1;

        // Write request during the sweep, withdrawn before any grant.
        busy_n = 0;
        a_req = 1; a_we = 1; a_addr = 13'h3; a_wdata = 8'hEE;
        repeat (5) begin
            @(negedge clk);
            if (clear_busy) busy_n++;
            chk("gnt_in_clear", 32'(a_gnt), 32'(0));
        end
        @(posedge clk); #1 a_req = 0;
        wait_sweep(busy_n);
        chk("clear_len", 32'(busy_n), 32'(DEPTH));

        for (int i = 0; i < 32; i++) begin
            op(0, 0, (i < 16) ? AW'(i) : AW'(DEPTH - 32 + i), 8'h00);
            rd_wait();
            chk("clear_rd_vld", 32'(a_rvalid), 32'(1));
            chk("clear_rd", 32'(a_rdata), 32'(CLR));
        end

        op(0, 1, 13'h0010, 8'h5A);
        op(0, 0, 13'h0010, 8'h00);
        rd_wait();
        chk("wr_rd_a_vld", 32'(a_rvalid), 32'(1));
        chk("wr_rd_a_dat", 32'(a_rdata), 32'h5A);
        chk("wr_rd_b_vld", 32'(b_rvalid), 32'(0));

        // Both ports reading every cycle: grants must alternate starting with A.
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = rnd_addr();
        b_req = 1; b_we = 0; b_addr = rnd_addr();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ga = a_gnt; gb = b_gnt;
            chk("alt_a", 32'(ga), 32'(k % 2 == 0));
            chk("alt_b", 32'(gb), 32'(k % 2));
            @(posedge clk); #1;
            if (ga) a_addr = rnd_addr();
            if (gb) b_addr = rnd_addr();
        end
        a_req = 0; b_req = 0;

        op(1, 1, 13'h1FFF, 8'hC3);
        op(1, 0, 13'h1FFF, 8'h00);
        rd_wait();
        chk("last_b_vld", 32'(b_rvalid), 32'(1));
        chk("last_b_dat", 32'(b_rdata), 32'hC3);
        chk("last_a_vld", 32'(a_rvalid), 32'(0));
        op(0, 0, 13'h0000, 8'h00);
        rd_wait();
        chk("addr0_kept", 32'(a_rdata), 32'(CLR));
        op(0, 0, 13'h0003, 8'h00);
        rd_wait();
        chk("no_clear_wr", 32'(a_rdata), 32'(CLR));

        repeat (3000) begin
            @(negedge clk);
            ga = a_gnt; gb = b_gnt;
            @(posedge clk); #1;
            if (ap && ga) ap = 0;
            if (ap && $urandom_range(0, 15) == 0) ap = 0;
            if (!ap && $urandom_range(0, 3) != 0) begin
                ap = 1; a_we = 1'($urandom_range(0, 1)); a_addr = rnd_addr(); a_wdata = DW'($urandom);
            end
            if (bp && gb) bp = 0;
            if (bp && $urandom_range(0, 15) == 0) bp = 0;
            if (!bp && $urandom_range(0, 3) != 0) begin
                bp = 1; b_we = 1'($urandom_range(0, 1)); b_addr = rnd_addr(); b_wdata = DW'($urandom);
            end
            a_req = ap; b_req = bp;
        end
        @(posedge clk); #1 a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);

        // Reset pulsed while an A read is in flight.
        op(0, 1, 13'h0010, 8'h5A);
        op(1, 1, 13'h1FFF, 8'hC3);
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 13'h0010;
        g = 0;
        forever begin
            @(negedge clk);
            if (a_gnt || g >= 64) break;
            g++;
        end
        chk("inflight_gnt", 32'(a_gnt), 32'(1));
        @(posedge clk); #1 reset_n = 0; a_req = 0;
        @(negedge clk);
        chk("drop_rvalid", 32'(a_rvalid), 32'(0));
        chk("drop_busy", 32'(clear_busy), 32'(1));
        chk("drop_rdata", 32'(a_rdata), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        busy_n = 0;
        wait_sweep(busy_n);
        chk("clear_len2", 32'(busy_n), 32'(DEPTH));
        op(0, 0, 13'h0010, 8'h00);
        rd_wait();
        chk("reclear_10", 32'(a_rdata), 32'(CLR));
        op(1, 0, 13'h1FFF, 8'h00);
        rd_wait();
        chk("reclear_1fff", 32'(b_rdata), 32'(CLR));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
